// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one digit per clock, valid/ready on both sides, signed/unsigned.
// Optional BOOTH_EARLY_TERM_EN: stop once the remaining multiplier digits are all zero.
module booth_mul_seq #(
  parameter int A_W = 256,
  parameter int B_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] p,
  output logic               busy
);
  localparam int P_W = A_W + B_W;
  localparam int N   = (B_W + 2) / 2;
  localparam int BE  = B_W + 2;        // extended multiplier width
  localparam int AE  = A_W + 2;        // extended multiplicand width
  localparam int H   = A_W + 3;        // accumulator: holds hi + 2A without overflow
  localparam int PR  = H + BE;
  localparam int CW  = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [AE-1:0]  a_q, a_d;
  logic [BE:0]    bq_q, bq_d;          // {b_ext, b[-1]}, shifted right 2 per digit
  logic [H-1:0]   hi_q, hi_d;
  logic [BE-1:0]  plo_q, plo_d;        // low product bits shifted in from the accumulator
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [P_W-1:0] p_q, p_d;

  logic [H-1:0]   a_x, pp, sum;
  logic [PR-1:0]  step;
  logic           last;

  assign a_x = {a_q[AE-1], a_q};

  always_comb begin
    pp = '0;
    case (bq_q[2:0])
      3'b001, 3'b010: pp = a_x;
      3'b011:         pp = a_x << 1;
      3'b100:         pp = -(a_x << 1);
      3'b101, 3'b110: pp = -a_x;
      default:        pp = '0;
    endcase
  end

  assign sum  = hi_q + pp;
  assign step = $signed({sum, plo_q}) >>> 2;

`ifdef BOOTH_EARLY_TERM_EN
  localparam logic [CW:0] N_L = (CW+1)'(N);
  logic          rest_uniform;
  logic [CW+1:0] sh_amt;
  // Arithmetic shifting of bq_q keeps the extension bit replicated above the live digits.
  assign rest_uniform = (bq_q[BE:2] == '0) || (bq_q[BE:2] == '1);
  assign sh_amt       = {N_L - {1'b0, cnt_q}, 1'b0};
  assign last         = (cnt_q == CW'(N-1)) || rest_uniform;
`else
  assign last         = (cnt_q == CW'(N-1));
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bq_d    = bq_q;
    hi_d    = hi_q;
    plo_d   = plo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_RUN;
        a_d     = {{2{signed_mode & a[A_W-1]}}, a};
        bq_d    = {{2{signed_mode & b[B_W-1]}}, b, 1'b0};
        hi_d    = '0;
        plo_d   = '0;
        cnt_d   = '0;
      end
      S_RUN: begin
        hi_d  = step[PR-1:BE];
        plo_d = step[BE-1:0];
        bq_d  = $signed(bq_q) >>> 2;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
`ifdef BOOTH_EARLY_TERM_EN
          // Skipped digits are zero: apply all their shifts at once.
          p_d     = P_W'($signed({sum, plo_q}) >>> sh_amt);
`else
          p_d     = step[P_W-1:0];
`endif
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bq_q    <= '0;
      hi_q    <= '0;
      plo_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bq_q    <= bq_d;
      hi_q    <= hi_d;
      plo_q   <= plo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign p         = p_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq (default 256x64); latency expectations follow BOOTH_EARLY_TERM_EN.
module tb_booth_mul_seq;
  localparam int A_W = 256;
  localparam int B_W = 64;
  localparam int P_W = A_W + B_W;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [P_W-1:0] p;

  int n_tests = 0;
  int n_fail  = 0;

  booth_mul_seq #(.A_W(A_W), .B_W(B_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [P_W-1:0] got, input logic [P_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                        input logic sm, input logic [P_W-1:0] ep, input int lat_full, input int lat_et);
    int c;
    chk({tag, ".rdy"}, P_W'(in_ready), P_W'(1));
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".run"}, P_W'({out_valid, in_ready, busy}), P_W'(3'b001));
    c = 1;
    while (!out_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, ".lat"}, P_W'(c), P_W'(ET ? lat_et : lat_full));
    chk({tag, ".p"}, p, ep);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".idle"}, P_W'({out_valid, in_ready, busy}), P_W'(3'b010));
  endtask

  initial begin
    int c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #1;
    chk("reset", P_W'({out_valid, in_ready, busy}), P_W'(3'b010));
    chk("reset.p", p, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op("u475x422", 256'd475, 64'd422, 1'b0, 320'd200450, 34, 6);
    run_op("s-3x5", ~256'd2, 64'd5, 1'b1, ~320'd14, 34, 3);
    run_op("s_min_min", {1'b1, 255'd0}, {1'b1, 63'd0}, 1'b1, 320'd1 << 318, 34, 33);
    run_op("u_max", {256{1'b1}}, {64{1'b1}}, 1'b0,
           {64'hFFFF_FFFF_FFFF_FFFE, {192{1'b1}}, 64'h1}, 34, 34);
    run_op("s-1x-1", {256{1'b1}}, {64{1'b1}}, 1'b1, 320'd1, 34, 2);
    run_op("b_zero", 256'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 320'd0, 34, 2);
    run_op("s7x-9", 256'd7, ~64'd8, 1'b1, ~320'd62, 34, 4);

    // Back-pressure: result held, new operands ignored while DONE.
    a = 256'd11; b = 64'd13; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 256'd1; b = 64'd1;
    c = 1;
    while (!out_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("hold.arrive", P_W'(out_valid), P_W'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold.flags", P_W'({out_valid, in_ready, busy}), P_W'(3'b101));
      chk("hold.p", p, 320'd143);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold.release", P_W'({out_valid, in_ready, busy}), P_W'(3'b010));
    chk("hold.p_kept", p, 320'd143);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.no_accept", P_W'({out_valid, in_ready, busy}), P_W'(3'b010));

    // Reset in the middle of RUN.
    a = 256'd5; b = 64'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.flags", P_W'({out_valid, in_ready, busy}), P_W'(3'b010));
    chk("midrst.p", p, '0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op("u7x9", 256'd7, 64'd9, 1'b0, 320'd63, 34, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
